// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: command codes, FSM states and default sync marker for the framed UART receiver
package uart_rx_pkg;

    localparam logic [7:0] CMD_START    = 8'h01;
    localparam logic [7:0] CMD_SEL_CAM  = 8'h02;
    localparam logic [7:0] CMD_SEL_PC   = 8'h03;
    localparam logic [7:0] CMD_IMG      = 8'h10;
    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_PAYLOAD,
        ST_CHK,
        ST_WAIT_TX
    } state_t;

endpackage

// File: rtl/uart_rx_pix_pack.sv
// uart_rx_pix_pack: shifts payload bytes MSB-first into a pixel and flags the last byte of each pixel
module uart_rx_pix_pack #(
    parameter int PIX_BYTES = 2,
    parameter int PIX_WIDTH = 8 * PIX_BYTES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 en,
    input  logic [7:0]           din,
    output logic [PIX_WIDTH-1:0] pixel_next,
    output logic                 pixel_done
);

    logic [PIX_WIDTH-1:0] pix;
    logic [1:0]           cnt;

    assign pixel_next = PIX_WIDTH'({pix, din});
    assign pixel_done = en && cnt == 2'(PIX_BYTES - 1);

    // byte counter restarts per pixel; shift register needs no clear since a full pixel overwrites it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix <= '0;
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            pix <= pixel_next;
            cnt <= pixel_done ? 2'd0 : cnt + 2'd1;
        end
    end

endmodule

// File: rtl/uart_rx_frame_loader.sv
// uart_rx_frame_loader: decodes sync/command/pixel-payload/checksum packets from a show-ahead RX FIFO
module uart_rx_frame_loader
    import uart_rx_pkg::*;
#(
    parameter int         IMG_WIDTH   = 176,
    parameter int         IMG_HEIGHT  = 240,
    parameter int         PIX_BYTES   = 2,
    parameter int         PIX_WIDTH   = 8 * PIX_BYTES,
    parameter int         ADDR_WIDTH  = $clog2(IMG_WIDTH * IMG_HEIGHT),
    parameter int         TIMEOUT_CYC = 1_000_000,
    parameter logic [7:0] SYNC_BYTE   = SYNC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_empty,
    output logic                  rd_en,
    input  logic                  frame_tx_done,
    output logic                  start_edge_trig,
    output logic                  edge_input_sel,
    output logic                  fb_we,
    output logic [ADDR_WIDTH-1:0] fb_waddr,
    output logic [PIX_WIDTH-1:0]  fb_wdata,
    output logic                  receiving,
    output logic                  img_valid,
    output logic                  err_cmd,
    output logic                  err_chk,
    output logic                  err_timeout
);

    localparam int                  TW   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(IMG_WIDTH * IMG_HEIGHT - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] idx;
    logic [7:0]            chk;
    logic [TW-1:0]         tcnt;
    logic                  tmo;
    logic                  pix_done;
    logic [PIX_WIDTH-1:0]  pix_next;

    assign rd_en     = !rx_empty && state != ST_WAIT_TX;
    assign receiving = state == ST_CMD || state == ST_PAYLOAD || state == ST_CHK;
    assign tmo       = receiving && rx_empty && tcnt == TW'(TIMEOUT_CYC - 1);

    uart_rx_pix_pack #(
        .PIX_BYTES (PIX_BYTES),
        .PIX_WIDTH (PIX_WIDTH)
    ) u_pack (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (state != ST_PAYLOAD),
        .en         (rd_en && state == ST_PAYLOAD),
        .din        (rx_data),
        .pixel_next (pix_next),
        .pixel_done (pix_done)
    );

    // packet FSM with registered command actions, pixel writes, checksum and inter-byte timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            idx             <= '0;
            chk             <= '0;
            tcnt            <= '0;
            start_edge_trig <= 1'b0;
            edge_input_sel  <= 1'b0;
            fb_we           <= 1'b0;
            fb_waddr        <= '0;
            fb_wdata        <= '0;
            img_valid       <= 1'b0;
            err_cmd         <= 1'b0;
            err_chk         <= 1'b0;
            err_timeout     <= 1'b0;
        end else begin
            start_edge_trig <= 1'b0;
            fb_we           <= 1'b0;
            err_cmd         <= 1'b0;
            err_chk         <= 1'b0;
            err_timeout     <= 1'b0;
            tcnt            <= (receiving && rx_empty) ? tcnt + TW'(1) : '0;
            if (tmo) begin
                err_timeout <= 1'b1;
                state       <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: if (rd_en && rx_data == SYNC_BYTE) state <= ST_CMD;
                    ST_CMD: if (rd_en) begin
                        state <= rx_data == CMD_IMG ? ST_PAYLOAD : ST_IDLE;
                        case (rx_data)
                            CMD_START:   start_edge_trig <= 1'b1;
                            CMD_SEL_CAM: edge_input_sel  <= 1'b0;
                            CMD_SEL_PC:  edge_input_sel  <= 1'b1;
                            CMD_IMG: begin
                                img_valid <= 1'b0;
                                idx       <= '0;
                                chk       <= '0;
                            end
                            default:     err_cmd <= 1'b1;
                        endcase
                    end
                    ST_PAYLOAD: if (rd_en) begin
                        chk <= chk ^ rx_data;
                        if (pix_done) begin
                            fb_we    <= 1'b1;
                            fb_waddr <= idx;
                            fb_wdata <= pix_next;
                            idx      <= idx + 1'b1;
                            if (idx == LAST) state <= ST_CHK;
                        end
                    end
                    ST_CHK: if (rd_en) begin
                        if (rx_data == chk) begin
                            img_valid       <= 1'b1;
                            edge_input_sel  <= 1'b1;
                            start_edge_trig <= 1'b1;
                            state           <= ST_WAIT_TX;
                        end else begin
                            err_chk <= 1'b1;
                            state   <= ST_IDLE;
                        end
                    end
                    ST_WAIT_TX: if (frame_tx_done) state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_loader.sv
// tb_uart_rx_frame_loader: scoreboard bench for the framed UART receiver on a 2x2, 2-byte-pixel image
module tb_uart_rx_frame_loader;

    localparam int W = 2, H = 2, PB = 2, PW = 16, AW = 2, TO = 16;

    logic          clk = 0, rst_n = 0, rx_empty = 1, frame_tx_done = 0;
    logic [7:0]    rx_data = 0;
    logic          rd_en, start_edge_trig, edge_input_sel, fb_we, receiving, img_valid;
    logic          err_cmd, err_chk, err_timeout;
    logic [AW-1:0] fb_waddr;
    logic [PW-1:0] fb_wdata;

    int checks = 0, failures = 0;
    int n_start, n_cmd, n_chk, n_to, n_wr;
    bit stall_en = 0;
    logic [7:0]       fifo[$];
    logic [AW+PW-1:0] exp_q[$];
    logic [PW-1:0]    pix[4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};

    always #5 clk = ~clk;

    uart_rx_frame_loader #(
        .IMG_WIDTH (W), .IMG_HEIGHT (H), .PIX_BYTES (PB), .TIMEOUT_CYC (TO)
    ) dut (
        .clk (clk), .rst_n (rst_n), .rx_data (rx_data), .rx_empty (rx_empty), .rd_en (rd_en),
        .frame_tx_done (frame_tx_done), .start_edge_trig (start_edge_trig),
        .edge_input_sel (edge_input_sel), .fb_we (fb_we), .fb_waddr (fb_waddr),
        .fb_wdata (fb_wdata), .receiving (receiving), .img_valid (img_valid),
        .err_cmd (err_cmd), .err_chk (err_chk), .err_timeout (err_timeout)
    );

    // show-ahead FIFO model: present head at negedge, pop when rd_en is seen before the next posedge
    always begin
        @(negedge clk);
        rx_empty = fifo.size() == 0 || (stall_en && $urandom_range(0, 2) == 0);
        rx_data  = fifo.size() != 0 ? fifo[0] : 8'h00;
        #1;
        if (rd_en) void'(fifo.pop_front());
    end

    // pulse counters and frame-buffer write scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            n_start += int'(start_edge_trig);
            n_cmd   += int'(err_cmd);
            n_chk   += int'(err_chk);
            n_to    += int'(err_timeout);
            if (fb_we) begin
                n_wr++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write addr=%0h data=%0h", fb_waddr, fb_wdata);
                end else if ({fb_waddr, fb_wdata} !== exp_q[0]) begin
                    failures++;
                    $display("FAIL fb_write got=%0h/%0h exp=%0h/%0h", fb_waddr, fb_wdata,
                             exp_q[0][AW+PW-1:PW], exp_q[0][PW-1:0]);
                    void'(exp_q.pop_front());
                end else void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic clr_cnt();
        n_start = 0; n_cmd = 0; n_chk = 0; n_to = 0; n_wr = 0;
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
    endtask

    task automatic drain(output bit ok);
        for (int i = 0; i < 400 && fifo.size() != 0; i++) @(posedge clk);
        ok = fifo.size() == 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_image(input bit bad);
        logic [7:0] c = 8'h00;
        push(8'hA5); push(8'h10);
        for (int i = 0; i < W * H; i++) begin
            exp_q.push_back({AW'(i), pix[i]});
            push(pix[i][15:8]); push(pix[i][7:0]);
            c = c ^ pix[i][15:8] ^ pix[i][7:0];
        end
        push(bad ? ~c : c);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 400 && !img_valid; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({start_edge_trig, edge_input_sel, fb_we, fb_waddr, fb_wdata, receiving, img_valid,
             err_cmd, err_chk, err_timeout, rd_en} !== '0) begin
            failures++; $display("FAIL reset_outputs got nonzero exp 0");
        end
        rst_n = 1;
        repeat (2) @(negedge clk);
        checks++;
        if ({start_edge_trig, edge_input_sel, fb_we, receiving, img_valid} !== '0) begin
            failures++; $display("FAIL post_reset_idle got nonzero exp 0");
        end
    endtask

    task automatic test_commands();
        bit ok;
        clr_cnt();
        push(8'h01); push(8'h03); push(8'hA5); push(8'h01);
        drain(ok);
        checks++;
        if (!ok || n_start != 1) begin
            failures++; $display("FAIL start_pulse got=%0d exp=1", n_start);
        end
        checks++;
        if (edge_input_sel !== 1'b0) begin
            failures++; $display("FAIL sel_after_start got=%b exp=0", edge_input_sel);
        end
        push(8'hA5); push(8'h03);
        drain(ok);
        checks++;
        if (edge_input_sel !== 1'b1) begin
            failures++; $display("FAIL sel_pc got=%b exp=1", edge_input_sel);
        end
    endtask

    task automatic test_bad_cmd();
        bit ok;
        clr_cnt();
        push(8'hA5); push(8'h7F);
        drain(ok);
        checks++;
        if (n_cmd != 1) begin
            failures++; $display("FAIL err_cmd got=%0d exp=1", n_cmd);
        end
        push(8'hA5); push(8'h02);
        drain(ok);
        checks++;
        if (edge_input_sel !== 1'b0 || n_cmd != 1) begin
            failures++; $display("FAIL sel_cam_after_err got=%b/%0d exp=0/1", edge_input_sel, n_cmd);
        end
    endtask

    task automatic test_image_ok();
        bit ok;
        clr_cnt();
        send_image(0);
        push(8'h55);
        wait_valid();
        checks++;
        if (img_valid !== 1'b1) begin
            failures++; $display("FAIL img_valid got=%b exp=1", img_valid);
        end
        @(negedge clk);
        checks++;
        if (n_start != 1 || edge_input_sel !== 1'b1) begin
            failures++; $display("FAIL img_trig got=%0d/%b exp=1/1", n_start, edge_input_sel);
        end
        checks++;
        if (n_wr != 4 || exp_q.size() != 0) begin
            failures++; $display("FAIL img_writes got=%0d exp=4", n_wr);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (rd_en !== 1'b0 || fifo.size() != 1) begin
            failures++; $display("FAIL wait_tx_hold got rd_en=%b left=%0d exp 0/1", rd_en, fifo.size());
        end
        frame_tx_done = 1;
        @(negedge clk);
        frame_tx_done = 0;
        drain(ok);
        checks++;
        if (!ok || receiving !== 1'b0) begin
            failures++; $display("FAIL tx_done_release got left=%0d exp=0", fifo.size());
        end
    endtask

    task automatic test_image_bad();
        bit ok;
        clr_cnt();
        frame_tx_done = 1;
        send_image(1);
        drain(ok);
        frame_tx_done = 0;
        checks++;
        if (!ok || n_chk != 1 || n_start != 0) begin
            failures++; $display("FAIL err_chk got=%0d trig=%0d exp=1/0", n_chk, n_start);
        end
        checks++;
        if (img_valid !== 1'b0 || receiving !== 1'b0) begin
            failures++; $display("FAIL bad_img_state got=%b/%b exp=0/0", img_valid, receiving);
        end
        checks++;
        if (n_wr != 4 || exp_q.size() != 0) begin
            failures++; $display("FAIL bad_img_writes got=%0d exp=4", n_wr);
        end
    endtask

    task automatic test_timeout();
        bit early = 0;
        clr_cnt();
        push(8'hA5); push(8'h10); push(8'h12);
        for (int i = 0; i < 100 && fifo.size() != 0; i++) @(posedge clk);
        repeat (TO) begin
            @(negedge clk);
            if (err_timeout || !receiving) early = 1;
        end
        checks++;
        if (early) begin
            failures++; $display("FAIL timeout_early got=1 exp=0");
        end
        @(negedge clk);
        checks++;
        if (err_timeout !== 1'b1) begin
            failures++; $display("FAIL timeout_pulse got=%b exp=1", err_timeout);
        end
        @(negedge clk);
        checks++;
        if (receiving !== 1'b0 || img_valid !== 1'b0 || n_to != 1) begin
            failures++; $display("FAIL timeout_exit got=%b/%b/%0d exp=0/0/1", receiving, img_valid, n_to);
        end
    endtask

    task automatic test_random_stall();
        bit ok;
        clr_cnt();
        stall_en = 1;
        send_image(0);
        wait_valid();
        stall_en = 0;
        checks++;
        if (img_valid !== 1'b1 || n_chk != 0 || n_to != 0) begin
            failures++; $display("FAIL stall_img got=%b/%0d/%0d exp=1/0/0", img_valid, n_chk, n_to);
        end
        @(negedge clk);
        checks++;
        if (n_wr != 4 || exp_q.size() != 0) begin
            failures++; $display("FAIL stall_writes got=%0d exp=4", n_wr);
        end
        frame_tx_done = 1;
        @(negedge clk);
        frame_tx_done = 0;
        drain(ok);
    endtask

    task automatic test_reset_mid();
        bit ok;
        clr_cnt();
        exp_q.push_back({AW'(0), pix[0]});
        push(8'hA5); push(8'h10); push(8'h12); push(8'h34); push(8'h56);
        for (int i = 0; i < 100 && n_wr == 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        checks++;
        if (receiving !== 1'b1 || n_wr != 1) begin
            failures++; $display("FAIL mid_payload got=%b/%0d exp=1/1", receiving, n_wr);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if ({start_edge_trig, edge_input_sel, fb_we, fb_waddr, fb_wdata, receiving, img_valid,
             err_cmd, err_chk, err_timeout} !== '0) begin
            failures++; $display("FAIL async_reset got nonzero exp 0");
        end
        fifo.delete();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1;
        clr_cnt();
        push(8'hA5); push(8'h01);
        drain(ok);
        checks++;
        if (n_start != 1 || n_wr != 0) begin
            failures++; $display("FAIL after_reset_cmd got=%0d/%0d exp=1/0", n_start, n_wr);
        end
    endtask

    initial begin
        test_reset();
        test_commands();
        test_bad_cmd();
        test_image_ok();
        test_image_bad();
        test_timeout();
        test_random_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
